// File: rtl/cic_interpolator.sv
// CIC interpolator: N combs clocked on input slots, zero-stuffing by R = 2**LOG2_R,
// then N integrators running every cycle once the first sample has been accepted.
module cic_interpolator #(
  parameter int DATA_WIDTH = 12,
  parameter int N          = 3,
  parameter int LOG2_R     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_WIDTH-1:0]                  x,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [DATA_WIDTH+(N-1)*LOG2_R-1:0]     y,
  output logic                                   out_valid,
  output logic                                   underrun
);

  localparam int OUT_WIDTH = DATA_WIDTH + (N - 1) * LOG2_R;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q;
  logic [LOG2_R-1:0]     phase_q;
  logic [DATA_WIDTH-1:0] x_last_q;
  logic [OUT_WIDTH-1:0]  u_q;

  logic                  last_phase;
  logic                  transfer;
  logic                  slot_underrun;
  logic                  slot;
  logic [DATA_WIDTH-1:0] comb_sel;
  logic [OUT_WIDTH-1:0]  comb_in;
  logic [OUT_WIDTH-1:0]  comb_out;
  logic [OUT_WIDTH-1:0]  integ_drive;

  assign last_phase    = (state_q == RUN) && (phase_q == {LOG2_R{1'b1}});
  assign in_ready      = (state_q == IDLE) || last_phase;
  assign transfer      = in_valid && in_ready;
  assign slot_underrun = last_phase && !in_valid;
  assign slot          = transfer || slot_underrun;
  assign out_valid     = (state_q == RUN);
  assign underrun      = slot_underrun;

  // A missed slot replays the last accepted sample so the comb history stays continuous.
  assign comb_sel = transfer ? x : x_last_q;
  assign comb_in  = OUT_WIDTH'($signed(comb_sel));

  for (genvar k = 0; k < N; k++) begin : g_comb
    logic [OUT_WIDTH-1:0] c_in;
    logic [OUT_WIDTH-1:0] c_out;
    logic [OUT_WIDTH-1:0] dly_q;

    if (k == 0) begin : g_head
      assign c_in = comb_in;
    end else begin : g_link
      assign c_in = g_comb[k-1].c_out;
    end

    assign c_out = c_in - dly_q;

    // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       dly_q <= '0;
      else if (slot) dly_q <= c_in;
    end
  end

  assign comb_out = g_comb[N-1].c_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      x_last_q <= '0;
      u_q      <= '0;
    end else begin
      if (transfer) begin
        state_q  <= RUN;
        phase_q  <= '0;
        x_last_q <= x;
      end else if (state_q == RUN) begin
        phase_q  <= phase_q + LOG2_R'(1);
      end
      if (slot) u_q <= comb_out;
    end
  end

  // Zero-stuffing: the comb result is injected once per slot, zeros on the other R-1 cycles.
  assign integ_drive = ((state_q == RUN) && (phase_q == '0)) ? u_q : '0;

  for (genvar k = 0; k < N; k++) begin : g_int
    logic [OUT_WIDTH-1:0] i_in;
    logic [OUT_WIDTH-1:0] i_q;

    if (k == 0) begin : g_head
      assign i_in = integ_drive;
    end else begin : g_link
      assign i_in = g_int[k-1].i_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                  i_q <= '0;
      else if (state_q == RUN)  i_q <= i_q + i_in;
    end
  end

  assign y = g_int[N-1].i_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: an N=3 and an N=1 instance share stimulus and are
// compared every cycle against a binomial-convolution model of the filter.
module tb_cic_interpolator;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] x;
  logic        in_valid;
  logic        rdy3, ov3, un3, rdy1, ov1, un1;
  logic [15:0] y3;
  logic [11:0] y1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_interpolator #(.DATA_WIDTH(12), .N(3), .LOG2_R(2)) u_dut3 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(rdy3),
    .y(y3), .out_valid(ov3), .underrun(un3)
  );

  cic_interpolator #(.DATA_WIDTH(12), .N(1), .LOG2_R(2)) u_dut1 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(rdy1),
    .y(y1), .out_valid(ov1), .underrun(un1)
  );

  // Reference: slot inputs form a sequence; comb output is its N-th difference,
  // the output is the N-fold running sum of the zero-stuffed comb stream.
  bit          m_run;
  int          m_phase;
  longint      m_xlast;
  longint      xin[$];
  longint      u3, u1;
  longint      v3[$];
  longint      v1[$];
  logic        e_ready, e_valid, e_under;
  logic [15:0] e_y3;
  logic [11:0] e_y1;
  logic [33:0] obs_v, exp_v;

  function automatic longint binom(int n, int k);
    longint r = 1;
    if (k < 0 || n < k) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint comb_out(int n_st);
    longint s = 0;
    int     n = xin.size() - 1;
    for (int k = 0; k <= n_st; k++)
      if (n - k >= 0) s += ((k % 2) ? -1 : 1) * binom(n_st, k) * xin[n - k];
    return s;
  endfunction

  function automatic longint integ_out(int n_st);
    longint s = 0;
    int     e = (n_st == 3) ? v3.size() : v1.size();
    for (int j = 0; j < e; j++)
      s += ((n_st == 3) ? v3[j] : v1[j]) * binom(e - 1 - j, n_st - 1);
    return s;
  endfunction

  function automatic bit model_ready();
    return !m_run || (m_phase == R - 1);
  endfunction

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_xlast = 0; u3 = 0; u1 = 0;
    xin.delete(); v3.delete(); v1.delete();
  endtask

  task automatic model_advance();
    bit tr, un;
    tr = in_valid && model_ready();
    un = m_run && (m_phase == R - 1) && !in_valid;
    if (m_run) begin
      v3.push_back((m_phase == 0) ? u3 : 0);
      v1.push_back((m_phase == 0) ? u1 : 0);
    end
    if (tr || un) begin
      xin.push_back(tr ? longint'($signed(x)) : m_xlast);
      u3 = comb_out(3);
      u1 = comb_out(1);
    end
    if (tr) m_xlast = longint'($signed(x));
    m_phase = tr ? 0 : (m_run ? (m_phase + 1) % R : 0);
    m_run   = m_run || tr;
  endtask

  // Drive inputs, move to the falling edge, and capture observed and predicted outputs.
  task automatic step(input logic [11:0] xv, input logic vv);
    x = xv;
    in_valid = vv;
    @(negedge clk);
    e_ready = model_ready();
    e_valid = m_run;
    e_under = m_run && (m_phase == R - 1) && !in_valid;
    e_y3    = 16'(integ_out(3));
    e_y1    = 12'(integ_out(1));
    obs_v   = {y3, y1, rdy3, ov3, un3, rdy1, ov1, un1};
    exp_v   = {e_y3, e_y1, e_ready, e_valid, e_under, e_ready, e_valid, e_under};
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    x = '0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; x = '0;
    model_reset();
    #2;
    checks++;
    if ({y3, y1, rdy3, ov3, un3, rdy1, ov1, un1} !== {16'h0, 12'h0, 6'b100100}) begin
      errors++;
      $display("FAIL reset_hold: got y3=%h y1=%h flags=%b%b%b/%b%b%b expected zeros, ready=1",
               y3, y1, rdy3, ov3, un3, rdy1, ov1, un1);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      step(12'($urandom), 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h expected %h", i, obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    int sent = 0, fives = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      step(model_ready() ? ((sent == 0) ? 12'd5 : 12'd0) : 12'($urandom), 1'b1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL hold cycle %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (ov1 && y1 === 12'd5) fives++;
      if (e_ready) sent++;
      tick();
    end
    checks++;
    if (fives != 4) begin
      errors++;
      $display("FAIL hold_count: got %0d outputs of 5, expected 4", fives);
    end
  endtask

  task automatic test_dc_gain();
    logic [11:0] level [2];
    logic [15:0] want3 [2];
    level[0] = 12'd1;   want3[0] = 16'd16;
    level[1] = 12'h800; want3[1] = 16'h8000;
    for (int p = 0; p < 2; p++) begin
      apply_reset();
      for (int i = 0; i < 80; i++) begin
        step(level[p], 1'b1);
        checks++;
        if (obs_v !== exp_v) begin
          errors++;
          $display("FAIL dc_gain[%0d] cycle %0d: got %h expected %h", p, i, obs_v, exp_v);
        end
        tick();
      end
      checks++;
      if (y3 !== want3[p] || y1 !== level[p]) begin
        errors++;
        $display("FAIL dc_settle[%0d]: got y3=%h y1=%h expected y3=%h y1=%h",
                 p, y3, y1, want3[p], level[p]);
      end
    end
  endtask

  task automatic test_handshake();
    int run_cycles = 0, ready_run = 0;
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      step(12'($urandom), ($urandom % 4) != 0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL handshake cycle %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (ov3) begin
        run_cycles++;
        if (rdy3) ready_run++;
      end
      tick();
    end
    checks++;
    if (ready_run != run_cycles / R) begin
      errors++;
      $display("FAIL ready_rate: got %0d ready cycles in %0d run cycles, expected %0d",
               ready_run, run_cycles, run_cycles / R);
    end
  endtask

  task automatic test_underrun();
    bit dropped = 0;
    bit vv;
    int u1c = 0, u3c = 0, bad = 0;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      vv = 1'b1;
      if (i >= 40 && !dropped && model_ready()) begin
        vv = 1'b0;
        dropped = 1;
      end
      step(12'd7, vv);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL underrun cycle %0d: got %h expected %h", i, obs_v, exp_v);
      end
      u1c += int'(un1);
      u3c += int'(un3);
      if (i >= 8 && ov1 && y1 !== 12'd7) bad++;
      tick();
    end
    checks++;
    if (u1c != 1 || u3c != 1 || bad != 0 || y3 !== 16'd112) begin
      errors++;
      $display("FAIL underrun_pulse: got pulses %0d/%0d, off-level %0d, y3=%0d expected 1/1, 0, 112",
               u1c, u3c, bad, y3);
    end
  endtask

  task automatic test_impulse();
    int sent = 0, nz = 0;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      step(model_ready() ? ((sent == 0) ? 12'd1 : 12'd0) : 12'($urandom), 1'b1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL impulse cycle %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (y3 !== 16'd0) nz++;
      if (e_ready) sent++;
      tick();
    end
    checks++;
    if (nz == 0 || y3 !== 16'd0 || y1 !== 12'd0) begin
      errors++;
      $display("FAIL impulse_tail: got %0d nonzero outputs, final y3=%h y1=%h expected response then 0",
               nz, y3, y1);
    end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      step(12'($urandom), 1'b1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL midrun_pre cycle %0d: got %h expected %h", i, obs_v, exp_v);
      end
      tick();
    end
    x = 12'($urandom);
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({y3, y1, rdy3, ov3, un3, rdy1, ov1, un1} !== {16'h0, 12'h0, 6'b100100}) begin
      errors++;
      $display("FAIL midrun_reset: got y3=%h y1=%h flags=%b%b%b/%b%b%b expected zeros, ready=1",
               y3, y1, rdy3, ov3, un3, rdy1, ov1, un1);
    end
    model_reset();
    @(posedge clk);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      step(12'($urandom), i >= 6);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL midrun_post cycle %0d: got %h expected %h", i, obs_v, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_dc_gain();
    test_handshake();
    test_underrun();
    test_impulse();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
